// File: rtl/lif_pkg.sv
// Shared state encoding, default tuning constants and arithmetic helpers
// for the LIF sweep scheduler.
package lif_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        LEAK      = 3'd2,
        INTEGRATE = 3'd3,
        STORE     = 3'd4,
        COMMIT    = 3'd5
    } lif_state_e;

    localparam int c_THRESHOLD  = 200;
    localparam int c_WEIGHT     = 60;
    localparam int c_LEAK_SHIFT = 3;
    localparam int c_REFRACTORY = 4;

    // Sum at one bit wider than the operands, then clamp to the all-ones value of 'width' bits.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (33'd1 << width) - 33'd1;
        if (sum > max_val) begin
            return max_val[31:0];
        end else begin
            return sum[31:0];
        end
    endfunction

    function automatic logic [31:0] leak(input logic [31:0] p, input int unsigned shift);
        return p - (p >> shift);
    endfunction

endpackage

// File: rtl/lif_state_ram.sv
// Potential and refractory storage: one write port, a combinational load
// port for the sweep and a registered display read port.
module lif_state_ram #(
    parameter int c_NUM_NEURONS = 8,
    parameter int c_IDX_WIDTH   = 3,
    parameter int c_POT_WIDTH   = 8,
    parameter int c_REF_WIDTH   = 3
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_Wr_En,
    input  logic [c_IDX_WIDTH-1:0] i_Wr_Index,
    input  logic [c_POT_WIDTH-1:0] i_Wr_Potential,
    input  logic [c_REF_WIDTH-1:0] i_Wr_Refractory,
    input  logic [c_IDX_WIDTH-1:0] i_Ld_Index,
    output logic [c_POT_WIDTH-1:0] o_Ld_Potential,
    output logic [c_REF_WIDTH-1:0] o_Ld_Refractory,
    input  logic [c_IDX_WIDTH-1:0] i_Rd_Index,
    output logic [c_POT_WIDTH-1:0] o_Rd_Potential
);

    logic [c_POT_WIDTH-1:0] pot_q [c_NUM_NEURONS];
    logic [c_POT_WIDTH-1:0] pot_d [c_NUM_NEURONS];
    logic [c_REF_WIDTH-1:0] ref_q [c_NUM_NEURONS];
    logic [c_REF_WIDTH-1:0] ref_d [c_NUM_NEURONS];
    logic [c_POT_WIDTH-1:0] rd_pot_q;
    logic [c_POT_WIDTH-1:0] rd_pot_d;

    // Write-first: the display port sees a STORE result on the same edge it is written.
    always_comb begin
        pot_d = pot_q;
        ref_d = ref_q;
        if (i_Wr_En && (32'(i_Wr_Index) < c_NUM_NEURONS)) begin
            pot_d[i_Wr_Index] = i_Wr_Potential;
            ref_d[i_Wr_Index] = i_Wr_Refractory;
        end else begin
            pot_d = pot_q;
        end
        if (32'(i_Rd_Index) < c_NUM_NEURONS) begin
            rd_pot_d = pot_d[i_Rd_Index];
        end else begin
            rd_pot_d = '0;
        end
        if (32'(i_Ld_Index) < c_NUM_NEURONS) begin
            o_Ld_Potential  = pot_q[i_Ld_Index];
            o_Ld_Refractory = ref_q[i_Ld_Index];
        end else begin
            o_Ld_Potential  = '0;
            o_Ld_Refractory = '0;
        end
    end

    // Array and read-port registers.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            pot_q    <= '{default: '0};
            ref_q    <= '{default: '0};
            rd_pot_q <= '0;
        end else begin
            pot_q    <= pot_d;
            ref_q    <= ref_d;
            rd_pot_q <= rd_pot_d;
        end
    end

    assign o_Rd_Potential = rd_pot_q;

endmodule

// File: rtl/lif_sweep_scheduler.sv
// Once-per-frame leaky integrate-and-fire sweep over a small neuron bank,
// started by the falling edge of VSync.
module lif_sweep_scheduler #(
    parameter int c_NUM_NEURONS = 8,
    parameter int c_IDX_WIDTH   = 3,
    parameter int c_POT_WIDTH   = 8,
    parameter int c_THRESHOLD   = lif_pkg::c_THRESHOLD,
    parameter int c_WEIGHT      = lif_pkg::c_WEIGHT,
    parameter int c_LEAK_SHIFT  = lif_pkg::c_LEAK_SHIFT,
    parameter int c_REFRACTORY  = lif_pkg::c_REFRACTORY
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    input  logic                     i_VSync,
    input  logic                     i_Action_Potential,
    input  logic [c_IDX_WIDTH-1:0]   i_Rd_Index,
    output logic [c_POT_WIDTH-1:0]   o_Rd_Potential,
    output logic                     o_Spike,
    output logic [c_IDX_WIDTH-1:0]   o_Spike_Index,
    output logic [c_NUM_NEURONS-1:0] o_Fired,
    output logic                     o_Busy,
    output logic                     o_Overrun
);
    import lif_pkg::*;

    localparam int c_REF_WIDTH = $clog2(c_REFRACTORY + 1);

    lif_state_e               state_q, state_d;
    logic [c_IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [c_POT_WIDTH-1:0]   p_q, p_d;
    logic [c_REF_WIDTH-1:0]   r_q, r_d;
    logic                     pend_q, pend_d;
    logic                     vsync_q;
    logic [c_NUM_NEURONS-1:0] fired_prev_q, fired_prev_d;
    logic [c_NUM_NEURONS-1:0] fired_next_q, fired_next_d;
    logic [c_NUM_NEURONS-1:0] fired_q, fired_d;
    logic                     spike_q, spike_d;
    logic [c_IDX_WIDTH-1:0]   spike_idx_q, spike_idx_d;
    logic                     busy_q, busy_d;
    logic                     overrun_q, overrun_d;

    logic                     tick;
    logic                     neuron_in;
    logic                     wr_en;
    logic [c_POT_WIDTH-1:0]   wr_pot;
    logic [c_REF_WIDTH-1:0]   wr_ref;
    logic [c_POT_WIDTH-1:0]   ld_pot;
    logic [c_REF_WIDTH-1:0]   ld_ref;

    lif_state_ram #(
        .c_NUM_NEURONS (c_NUM_NEURONS),
        .c_IDX_WIDTH   (c_IDX_WIDTH),
        .c_POT_WIDTH   (c_POT_WIDTH),
        .c_REF_WIDTH   (c_REF_WIDTH)
    ) u_ram (
        .i_Clk           (i_Clk),
        .i_Rst           (i_Rst),
        .i_Wr_En         (wr_en),
        .i_Wr_Index      (idx_q),
        .i_Wr_Potential  (wr_pot),
        .i_Wr_Refractory (wr_ref),
        .i_Ld_Index      (idx_q),
        .o_Ld_Potential  (ld_pot),
        .o_Ld_Refractory (ld_ref),
        .i_Rd_Index      (i_Rd_Index),
        .o_Rd_Potential  (o_Rd_Potential)
    );

    // Sweep sequencing, neuron arithmetic and output pulses.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        p_d          = p_q;
        r_d          = r_q;
        pend_d       = pend_q | i_Action_Potential;
        fired_prev_d = fired_prev_q;
        fired_next_d = fired_next_q;
        fired_d      = fired_q;
        spike_d      = 1'b0;
        spike_idx_d  = '0;
        overrun_d    = 1'b0;
        neuron_in    = 1'b0;
        wr_en        = 1'b0;
        wr_pot       = p_q;
        wr_ref       = r_q;
        tick         = vsync_q & ~i_VSync;

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                p_d     = ld_pot;
                r_d     = ld_ref;
                state_d = LEAK;
            end
            LEAK: begin
                p_d     = c_POT_WIDTH'(leak(32'(p_q), c_LEAK_SHIFT));
                state_d = INTEGRATE;
            end
            INTEGRATE: begin
                // Neuron 0 consumes the button flag; a still-held button keeps it armed.
                if (idx_q == '0) begin
                    neuron_in = pend_q;
                    pend_d    = i_Action_Potential;
                end else begin
                    neuron_in = fired_prev_q[idx_q - c_IDX_WIDTH'(1)];
                end
                if (r_q == '0) begin
                    if (neuron_in) begin
                        p_d = c_POT_WIDTH'(sat_add(32'(p_q), 32'(c_WEIGHT), c_POT_WIDTH));
                    end else begin
                        p_d = p_q;
                    end
                end else begin
                    p_d = '0;
                    r_d = r_q - c_REF_WIDTH'(1);
                end
                state_d = STORE;
            end
            STORE: begin
                wr_en = 1'b1;
                if (32'(p_q) >= c_THRESHOLD) begin
                    wr_pot              = '0;
                    wr_ref              = c_REF_WIDTH'(c_REFRACTORY);
                    fired_next_d[idx_q] = 1'b1;
                    spike_d             = 1'b1;
                    spike_idx_d         = idx_q;
                end else begin
                    wr_pot              = p_q;
                    wr_ref              = r_q;
                    fired_next_d[idx_q] = 1'b0;
                end
                if (32'(idx_q) == c_NUM_NEURONS - 1) begin
                    state_d = COMMIT;
                end else begin
                    state_d = LOAD;
                    idx_d   = idx_q + c_IDX_WIDTH'(1);
                end
            end
            COMMIT: begin
                fired_prev_d = fired_next_q;
                fired_d      = fired_next_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            p_q          <= '0;
            r_q          <= '0;
            pend_q       <= 1'b0;
            vsync_q      <= 1'b0;
            fired_prev_q <= '0;
            fired_next_q <= '0;
            fired_q      <= '0;
            spike_q      <= 1'b0;
            spike_idx_q  <= '0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            p_q          <= p_d;
            r_q          <= r_d;
            pend_q       <= pend_d;
            vsync_q      <= i_VSync;
            fired_prev_q <= fired_prev_d;
            fired_next_q <= fired_next_d;
            fired_q      <= fired_d;
            spike_q      <= spike_d;
            spike_idx_q  <= spike_idx_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign o_Spike       = spike_q;
    assign o_Spike_Index = spike_idx_q;
    assign o_Fired       = fired_q;
    assign o_Busy        = busy_q;
    assign o_Overrun     = overrun_q;

endmodule

// File: tb/tb_lif_sweep_scheduler.sv
// Scoreboard bench for lif_sweep_scheduler: a frame-level LIF model predicts
// spikes, fired vectors and stored potentials; a monitor checks the DUT outputs.
module tb_lif_sweep_scheduler;

    localparam int N            = 8;
    localparam int SWEEP_CYCLES = 4 * N + 1;
    localparam int THRESH       = 200;
    localparam int WEIGHT       = 60;
    localparam int REFR         = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       vsync;
    logic       ap;
    logic [2:0] rd_idx;
    logic [7:0] rd_pot;
    logic       spike;
    logic [2:0] spike_idx;
    logic [7:0] fired;
    logic       busy;
    logic       overrun;

    always #5 clk = ~clk;

    lif_sweep_scheduler dut (
        .i_Clk              (clk),
        .i_Rst              (rst),
        .i_VSync            (vsync),
        .i_Action_Potential (ap),
        .i_Rd_Index         (rd_idx),
        .o_Rd_Potential     (rd_pot),
        .o_Spike            (spike),
        .o_Spike_Index      (spike_idx),
        .o_Fired            (fired),
        .o_Busy             (busy),
        .o_Overrun          (overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int mdl_pot   [N];
    int mdl_ref   [N];
    bit mdl_fprev [N];
    bit mdl_pend;

    int         exp_spike_q [$];
    logic [7:0] exp_fired_q [$];
    int         exp_rd_q    [$];
    int exp_overruns  = 0;
    int seen_overruns = 0;
    int exp_sweeps    = 0;
    int seen_sweeps   = 0;
    int busy_cnt      = 0;
    bit rd_tag        = 1'b0;
    bit rd_tag_d      = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mdl_pot[k]   = 0;
            mdl_ref[k]   = 0;
            mdl_fprev[k] = 1'b0;
        end
        mdl_pend = 1'b0;
    endtask

    // One whole frame of the neuron bank, computed neuron by neuron.
    task automatic model_frame();
        bit         fnext [N];
        logic [7:0] vec;
        int         p;
        bit         in_spk;
        vec = 8'h00;
        for (int k = 0; k < N; k++) begin
            p      = mdl_pot[k];
            p      = p - p / 8;
            in_spk = (k == 0) ? mdl_pend : mdl_fprev[k-1];
            if (mdl_ref[k] == 0) begin
                if (in_spk) p = (p + WEIGHT > 255) ? 255 : p + WEIGHT;
            end else begin
                p = 0;
                mdl_ref[k] = mdl_ref[k] - 1;
            end
            if (p >= THRESH) begin
                mdl_pot[k] = 0;
                mdl_ref[k] = REFR;
                fnext[k]   = 1'b1;
                vec[k]     = 1'b1;
                exp_spike_q.push_back(k);
            end else begin
                mdl_pot[k] = p;
                fnext[k]   = 1'b0;
            end
        end
        for (int k = 0; k < N; k++) mdl_fprev[k] = fnext[k];
        exp_fired_q.push_back(vec);
        exp_sweeps++;
    endtask

    always @(posedge clk) rd_tag_d <= rd_tag;

    // Monitor: pops expectations whenever the DUT presents a result.
    always @(negedge clk) begin
        if (spike) begin
            if (exp_spike_q.size() == 0) check("spike_unexpected", int'(spike_idx), -1);
            else check("spike_index", int'(spike_idx), exp_spike_q.pop_front());
        end
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (rd_tag_d) begin
                if (exp_rd_q.size() == 0) check("rd_unexpected", int'(rd_pot), -1);
                else check("rd_potential", int'(rd_pot), exp_rd_q.pop_front());
            end
            if (overrun) seen_overruns++;
            if (busy) begin
                busy_cnt++;
            end else if (busy_cnt != 0) begin
                check("busy_cycles", busy_cnt, SWEEP_CYCLES);
                if (exp_fired_q.size() == 0) check("fired_unexpected", int'(fired), -1);
                else check("fired_vector", int'(fired), int'(exp_fired_q.pop_front()));
                seen_sweeps++;
                busy_cnt = 0;
            end
        end
    end

    task automatic wait_busy_rise();
        int t = 0;
        while (!busy && t < 8) begin
            @(negedge clk);
            t++;
        end
        if (!busy) check("sweep_start_timeout", 0, 1);
    endtask

    task automatic wait_busy_fall();
        int t = 0;
        while (busy && t < 80) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("sweep_end_timeout", 1, 0);
        @(negedge clk);
    endtask

    task automatic send_tick();
        @(negedge clk) vsync = 1'b1;
        @(negedge clk) vsync = 1'b0;
    endtask

    // mode 0: no button, 1: one-cycle pulse before the tick, 2: held through the sweep
    task automatic frame(input int mode);
        if (mode == 1) begin
            @(negedge clk) ap = 1'b1;
            @(negedge clk) ap = 1'b0;
        end else begin
            ap = (mode == 2);
        end
        if (mode != 0) mdl_pend = 1'b1;
        model_frame();
        mdl_pend = mdl_pend && (mode == 2);
        send_tick();
        wait_busy_rise();
        wait_busy_fall();
    endtask

    task automatic overrun_frame();
        ap = 1'b0;
        model_frame();
        exp_overruns++;
        send_tick();
        wait_busy_rise();
        repeat (9) @(negedge clk);
        send_tick();
        wait_busy_fall();
        repeat (4) @(negedge clk);
    endtask

    task automatic read_all();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            rd_idx = 3'(i);
            exp_rd_q.push_back(mdl_pot[i]);
            rd_tag = 1'b1;
        end
        @(negedge clk) rd_tag = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ap  = 1'b0;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        vsync  = 1'b0;
        ap     = 1'b0;
        rd_idx = 3'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_spike", int'(spike), 0);
        check("rst_fired", int'(fired), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_rd_potential", int'(rd_pot), 0);
        @(negedge clk) rst = 1'b0;

        repeat (3) frame(0);
        read_all();

        // Button held: neuron 0 climbs, fires, goes refractory, drives neuron 1.
        repeat (9) begin
            frame(2);
            read_all();
        end

        do_reset();
        frame(1);
        read_all();
        repeat (3) begin
            frame(0);
            read_all();
        end

        overrun_frame();
        read_all();

        // Abort a sweep at neuron 3's STORE cycle.
        do_reset();
        frame(2);
        frame(2);
        ap = 1'b1;
        send_tick();
        wait_busy_rise();
        repeat (15) @(negedge clk);
        rst = 1'b1;
        ap  = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_spike", int'(spike), 0);
        check("abort_fired", int'(fired), 0);
        @(negedge clk) rst = 1'b0;
        model_reset();
        exp_spike_q.delete();
        read_all();

        repeat (30) begin
            if ($urandom_range(0, 5) == 0) overrun_frame();
            else frame(int'($urandom_range(0, 2)));
            read_all();
        end

        check("pending_spikes", exp_spike_q.size(), 0);
        check("pending_sweeps", exp_fired_q.size(), 0);
        check("pending_reads", exp_rd_q.size(), 0);
        check("overrun_count", seen_overruns, exp_overruns);
        check("sweep_count", seen_sweeps, exp_sweeps);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lif_sweep_scheduler.md
Name: lif_sweep_scheduler

Overview:
- Sequences leaky integrate-and-fire (LIF) updates for a small bank of neurons, once per video frame.
- A falling edge of the VSync input starts a sweep through every neuron: load, leak, integrate, fire/store.
- The button action potential drives neuron 0. Each later neuron k is driven by neuron k-1's spike from the previous frame.
- Provides a registered read port so the pixel/draw logic can fetch any neuron's potential for display.

Parameters:
- c_NUM_NEURONS, 8: neurons in the bank; must be at least 2.
- c_IDX_WIDTH, 3: index width; must satisfy 2**c_IDX_WIDTH >= c_NUM_NEURONS.
- c_POT_WIDTH, 8: membrane potential width, unsigned.
- c_THRESHOLD, 200: fire when the post-integrate potential is >= this value.
- c_WEIGHT, 60: increment applied per input spike.
- c_LEAK_SHIFT, 3: leak amount is p >> c_LEAK_SHIFT.
- c_REFRACTORY, 4: frames a neuron ignores input after firing.

Ports:
- i_Clk  in  1  pixel clock.
- i_Rst  in  1  reset, synchronous, active-high.
- i_VSync  in  1  vertical sync, registered as in the sync counter path; its falling edge is the frame tick.
- i_Action_Potential  in  1  button spike request for neuron 0; level, already debounced.
- i_Rd_Index  in  c_IDX_WIDTH  neuron to read for display.
- o_Rd_Potential  out  c_POT_WIDTH  stored potential of i_Rd_Index, 1-cycle latency.
- o_Spike  out  1  one-cycle pulse when a neuron fires.
- o_Spike_Index  out  c_IDX_WIDTH  index of the firing neuron; valid with o_Spike.
- o_Fired  out  c_NUM_NEURONS  fired vector of the last completed sweep.
- o_Busy  out  1  high while a sweep is in progress.
- o_Overrun  out  1  one-cycle pulse when a frame tick arrives while busy.

Behaviour:
- Reset values:
  - All potentials, refractory counters and both fired vectors are 0.
  - Pending-button flag and VSync edge register are 0.
  - All outputs are 0; FSM is in IDLE.
- Frame tick: r_VSync_d is 1 and i_VSync is 0.
  - In IDLE, the tick moves the FSM to LOAD with index 0 on the next cycle.
  - Otherwise the tick is dropped and o_Overrun pulses.
- Pending button flag:
  - Set on any cycle i_Action_Potential is 1.
  - Cleared in neuron 0's INTEGRATE cycle, unless i_Action_Potential is high that same cycle, in which case it stays set.
- FSM: IDLE -> LOAD -> LEAK -> INTEGRATE -> STORE, then back to LOAD for index+1, or to COMMIT after the last neuron, then IDLE. Per cycle:
  - LOAD: working potential p and refractory count r are read from the arrays at the current index.
  - LEAK: p <= p - (p >> c_LEAK_SHIFT). Never underflows.
  - INTEGRATE: input is the pending flag for index 0, or fired_prev[index-1] otherwise.
    - If r == 0 and input is 1: p <= min(p + c_WEIGHT, 2**c_POT_WIDTH - 1). The add is computed at c_POT_WIDTH+1 bits, then saturated.
    - If r != 0: input is ignored, p <= 0, and r decrements.
  - STORE:
    - If p >= c_THRESHOLD: store potential 0, store r = c_REFRACTORY, set fired_next[index], and pulse o_Spike with o_Spike_Index = index.
    - Otherwise store p and r, and clear fired_next[index].
  - COMMIT: fired_prev <= fired_next; o_Fired <= fired_next.
- Sweep length: 4*c_NUM_NEURONS + 1 cycles (33 at defaults). o_Busy is high from the first LOAD through COMMIT inclusive.
- Read port: o_Rd_Potential <= potential[i_Rd_Index] every cycle, including during a sweep; values committed by STORE are visible the cycle after.
  - An out-of-range index returns 0.
- Reset asserted mid-sweep: immediate return to IDLE with all state cleared as above; no o_Spike is emitted.
- Simultaneous tick and reset: reset wins.

Decomposition:
- Shared package lif_pkg holds:
  - FSM state enum: IDLE, LOAD, LEAK, INTEGRATE, STORE, COMMIT.
  - Default constants c_THRESHOLD, c_WEIGHT, c_LEAK_SHIFT, c_REFRACTORY.
  - Saturating-add and leak functions.
- One sub-module: lif_state_ram. It holds the potential and refractory arrays, with one write port driven by STORE, one read port for LOAD and one read port for display.

Test Plan:
- Reset, then 3 frame ticks with no button -> all potentials 0, o_Spike never high, o_Busy high exactly 33 cycles per tick.
- Button held over frames 1-4 -> neuron 0 potential 60, 113, 159, then fires at frame 4.
  - The frame-4 fire pulses o_Spike with index 0 and stores potential 0.
  - o_Fired = 8'h01 after frame 4.
- Continue after that fire -> neuron 1 reads 60 after frame 5.
  - Neuron 0 stays 0 for frames 5-8 despite the button (refractory).
  - Neuron 0 reads 60 at frame 9.
- Single 1-cycle button pulse between frames, then ticks -> neuron 0 is 60, then leaks 53, 47, 42; the pending flag is consumed exactly once.
- Frame tick injected 10 cycles into a sweep -> o_Overrun pulses once; the sweep completes unchanged; no second sweep starts.
- i_Rst asserted mid-sweep at neuron 3 STORE -> next cycle o_Busy = 0, all reads return 0, and no o_Spike occurs.
